// File: rtl/acc_tile_buf.sv
// acc_tile_buf: accumulating tile buffer that feeds the post-processing unit (PPU).
//
// Collects 16-lane partial-sum rows over k_lat K passes into a 16x16 tile of
// ACC_W-bit signed sums. When the tile is complete it pulses o_ppu_start for
// one cycle, then streams rows 0..15 on 16 consecutive cycles.
//
// Build option: define ACC_SAT_EN to saturate each lane add. Without it, lane
// adds wrap modulo 2^ACC_W. Pass 0 sign-extends and overwrites in both builds.
//
// Ports:
//   i_clk, i_rst_n        clock; asynchronous active-low reset
//   i_k_tiles             K passes per tile (0 is treated as 1), latched on first beat
//   i_psum_valid/_data    partial-sum row in; lane g at [g*PSUM_W +: PSUM_W]
//   o_psum_ready          a row is accepted this cycle when valid is also high
//   o_ppu_start           one-cycle pulse, tile ready
//   o_acc_valid/_data/_row accumulated row out; lane g at [g*ACC_W +: ACC_W]
//   o_busy                tile in progress (first beat accepted until drain done)
module acc_tile_buf #(
  parameter int unsigned PSUM_W = 20,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LANES  = 16,
  parameter int unsigned ROWS   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [7:0]                i_k_tiles,
  input  logic                      i_psum_valid,
  input  logic [PSUM_W*LANES-1:0]   i_psum_data,
  output logic                      o_psum_ready,
  output logic                      o_ppu_start,
  output logic [ACC_W*LANES-1:0]    o_acc_data,
  output logic                      o_acc_valid,
  output logic [3:0]                o_acc_row,
  output logic                      o_busy
);

  typedef enum logic [1:0] {StAcc, StStart, StDrain} state_e;

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     start_q, start_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic [3:0]               row_cnt_q, row_cnt_d;
  logic [7:0]               k_cnt_q, k_cnt_d;
  logic [7:0]               k_lat_q, k_lat_d;
  logic [3:0]               drain_cnt_q, drain_cnt_d;
  logic [ACC_W*LANES-1:0]   acc_data_q, acc_data_d;

  logic [ACC_W*LANES-1:0]   mem_q [ROWS];
  logic [ACC_W*LANES-1:0]   row_wr;
  logic                     mem_we;

  logic                     accept;
  logic                     first_beat;
  logic                     last_beat;
  logic [7:0]               k_in_eff;
  logic [7:0]               k_eff;

  // ready_q is only ever set while in StAcc, so it alone qualifies a beat.
  assign accept     = i_psum_valid && ready_q;
  assign first_beat = (k_cnt_q == 8'd0) && (row_cnt_q == 4'd0);
  assign k_in_eff   = (i_k_tiles == 8'd0) ? 8'd1 : i_k_tiles;
  // The first beat of a tile must use the live K value, not the stale latch.
  assign k_eff      = first_beat ? k_in_eff : k_lat_q;
  assign last_beat  = (row_cnt_q == 4'hF) && (k_cnt_q == k_eff - 8'd1);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PSUM_W-1:0] psum;
    logic signed [ACC_W-1:0]  ext;
    logic signed [ACC_W-1:0]  old;
    logic signed [ACC_W-1:0]  add;

    assign psum = i_psum_data[g*PSUM_W +: PSUM_W];
    assign ext  = ACC_W'(psum);
    assign old  = mem_q[row_cnt_q][g*ACC_W +: ACC_W];

`ifdef ACC_SAT_EN
    logic signed [ACC_W:0] sum;
    assign sum = (ACC_W+1)'(old) + (ACC_W+1)'(ext);
    // Overflow iff the extra sign bit disagrees with the result sign bit.
    always_comb begin
      add = sum[ACC_W-1:0];
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
`else
    assign add = old + ext;
`endif

    assign row_wr[g*ACC_W +: ACC_W] = (k_cnt_q == 8'd0) ? ext : add;
  end

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    row_cnt_d   = row_cnt_q;
    k_cnt_d     = k_cnt_q;
    k_lat_d     = k_lat_q;
    drain_cnt_d = drain_cnt_q;
    acc_data_d  = acc_data_q;
    mem_we      = 1'b0;

    case (state_q)
      StAcc: begin
        if (accept) begin
          mem_we    = 1'b1;
          busy_d    = 1'b1;
          row_cnt_d = row_cnt_q + 4'd1;
          if (first_beat) begin
            k_lat_d = k_in_eff;
          end
          if (row_cnt_q == 4'hF) begin
            k_cnt_d = k_cnt_q + 8'd1;
          end
          if (last_beat) begin
            state_d = StStart;
            start_d = 1'b1;
          end
        end
      end
      StStart: begin
        state_d     = StDrain;
        drain_cnt_d = 4'd0;
        valid_d     = 1'b1;
        acc_data_d  = mem_q[0];
      end
      StDrain: begin
        if (drain_cnt_q == 4'hF) begin
          state_d   = StAcc;
          busy_d    = 1'b0;
          row_cnt_d = 4'd0;
          k_cnt_d   = 8'd0;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
          valid_d     = 1'b1;
          acc_data_d  = mem_q[drain_cnt_q + 4'd1];
        end
      end
      default: state_d = StAcc;
    endcase

    ready_d = (state_d == StAcc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StAcc;
      ready_q     <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      row_cnt_q   <= 4'd0;
      k_cnt_q     <= 8'd0;
      k_lat_q     <= 8'd0;
      drain_cnt_q <= 4'd0;
      acc_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      row_cnt_q   <= row_cnt_d;
      k_cnt_q     <= k_cnt_d;
      k_lat_q     <= k_lat_d;
      drain_cnt_q <= drain_cnt_d;
      acc_data_q  <= acc_data_d;
    end
  end

  // Tile storage needs no reset: pass 0 overwrites every row before it is read.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[row_cnt_q] <= row_wr;
    end
  end

  assign o_psum_ready = ready_q;
  assign o_ppu_start  = start_q;
  assign o_acc_valid  = valid_q;
  assign o_acc_data   = acc_data_q;
  assign o_acc_row    = drain_cnt_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_acc_tile_buf.sv
// tb_acc_tile_buf: randomized self-checking bench for acc_tile_buf.
// A lane-level integer model accumulates every beat and predicts each drained row.
module tb_acc_tile_buf;
  localparam int PSUM_W = 20;
  localparam int ACC_W  = 24;
  localparam int LANES  = 16;
  localparam int ROWS   = 16;
  localparam int DW     = PSUM_W * LANES;
  localparam int AW     = ACC_W * LANES;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    k_tiles;
  logic          psum_valid;
  logic [DW-1:0] psum_data;
  logic          psum_ready;
  logic          ppu_start;
  logic [AW-1:0] acc_data;
  logic          acc_valid;
  logic [3:0]    acc_row;
  logic          busy;

  acc_tile_buf #(
    .PSUM_W(PSUM_W),
    .ACC_W (ACC_W),
    .LANES (LANES),
    .ROWS  (ROWS)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_k_tiles   (k_tiles),
    .i_psum_valid(psum_valid),
    .i_psum_data (psum_data),
    .o_psum_ready(psum_ready),
    .o_ppu_start (ppu_start),
    .o_acc_data  (acc_data),
    .o_acc_valid (acc_valid),
    .o_acc_row   (acc_row),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  longint        acc [ROWS][LANES];
  logic [DW-1:0] beats[$];

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic longint lane_val(input logic [DW-1:0] beat, input int g);
    logic signed [PSUM_W-1:0] s;
    s = beat[g*PSUM_W +: PSUM_W];
    return longint'(s);
  endfunction

  // Reduce an exact sum to the representable ACC_W-bit result.
  function automatic longint fold(input longint x);
    longint hi, lo, m;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_W - 1));
`ifdef ACC_SAT_EN
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
`else
    m = x & ((longint'(1) <<< ACC_W) - 1);
    if (m > hi) m = m - (longint'(1) <<< ACC_W);
    return m;
`endif
  endfunction

  function automatic logic [AW-1:0] exp_row(input int r);
    logic [AW-1:0] v;
    longint        a;
    for (int g = 0; g < LANES; g++) begin
      a = acc[r][g];
      v[g*ACC_W +: ACC_W] = a[ACC_W-1:0];
    end
    return v;
  endfunction

  // Entered just after a negedge with the DUT idle and ready; returns at the
  // negedge where ready has come back (T+17). beats holds all 16*K rows.
  task automatic run_tile(input int k_in, input bit hold, input logic [DW-1:0] marker,
                          input bit scramble);
    int keff;
    keff = (k_in == 0) ? 1 : k_in;
    if (beats.size() != 16 * keff) begin
      $display("FAIL beat_count: got %0d expected %0d", beats.size(), 16 * keff);
      $fatal(1);
    end
    for (int b = 0; b < 16 * keff; b++) begin
      for (int g = 0; g < LANES; g++) begin
        if (b / 16 == 0) acc[b % 16][g] = lane_val(beats[b], g);
        else acc[b % 16][g] = fold(acc[b % 16][g] + lane_val(beats[b], g));
      end
    end
    for (int b = 0; b < 16 * keff; b++) begin
      check("ready_beat", AW'(psum_ready), AW'(1'b1));
      check("no_start_beat", AW'(ppu_start), AW'(1'b0));
      check("busy_beat", AW'(busy), AW'(b != 0));
      psum_valid = 1'b1;
      psum_data  = beats[b];
      if (b == 0) k_tiles = 8'(k_in);
      else if (scramble) k_tiles = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    // Cycle T
    if (hold) psum_data = marker;
    else begin
      psum_valid = 1'b0;
      psum_data  = DW'({$urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom, $urandom});
    end
    check("start_T", AW'(ppu_start), AW'(1'b1));
    check("ready_T", AW'(psum_ready), AW'(1'b0));
    check("busy_T", AW'(busy), AW'(1'b1));
    check("valid_T", AW'(acc_valid), AW'(1'b0));
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      check("drain_valid", AW'(acc_valid), AW'(1'b1));
      check("drain_row", AW'(acc_row), AW'(r));
      check("drain_data", acc_data, exp_row(r));
      check("drain_no_start", AW'(ppu_start), AW'(1'b0));
      check("drain_ready", AW'(psum_ready), AW'(1'b0));
    end
    @(negedge clk);
    check("ready_T17", AW'(psum_ready), AW'(1'b1));
    check("busy_T17", AW'(busy), AW'(1'b0));
    check("valid_T17", AW'(acc_valid), AW'(1'b0));
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int g = 0; g < LANES; g++) v[g*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
    return v;
  endfunction

  task automatic fill_random(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(rand_beat());
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] marker;
    int            k;

    rst_n      = 1'b0;
    k_tiles    = 8'd1;
    psum_valid = 1'b0;
    psum_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", AW'(psum_ready), AW'(1'b0));
    check("rst_start", AW'(ppu_start), AW'(1'b0));
    check("rst_valid", AW'(acc_valid), AW'(1'b0));
    check("rst_data", acc_data, AW'(0));
    check("rst_row", AW'(acc_row), AW'(0));
    check("rst_busy", AW'(busy), AW'(1'b0));
    rst_n = 1'b1;
    #1 check("ready_before_edge", AW'(psum_ready), AW'(1'b0));
    @(negedge clk);

    // K=1, lane g of row r = r*16+g
    beats.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int g = 0; g < LANES; g++) v[g*PSUM_W +: PSUM_W] = PSUM_W'(r * 16 + g);
      beats.push_back(v);
    end
    run_tile(1, 1'b0, '0, 1'b0);

    // K=3, every lane -5, back-to-back
    beats.delete();
    for (int g = 0; g < LANES; g++) v[g*PSUM_W +: PSUM_W] = PSUM_W'(-5);
    for (int i = 0; i < 48; i++) beats.push_back(v);
    run_tile(3, 1'b0, '0, 1'b0);

    // i_k_tiles=0 behaves as K=1
    fill_random(16);
    run_tile(0, 1'b0, '0, 1'b0);

    // K=40 at the positive lane limit: saturates or wraps depending on build
    beats.delete();
    for (int g = 0; g < LANES; g++) v[g*PSUM_W +: PSUM_W] = 20'h7FFFF;
    for (int i = 0; i < 640; i++) beats.push_back(v);
    run_tile(40, 1'b0, '0, 1'b0);

    // Valid held with a marker through start/drain; marker becomes next tile's row 0
    marker = rand_beat();
    fill_random(32);
    run_tile(2, 1'b1, marker, 1'b0);
    fill_random(16);
    beats[0] = marker;
    run_tile(1, 1'b0, '0, 1'b0);

    // Reset after beat 20 of a K=2 tile, then a fresh K=1 tile
    for (int b = 0; b < 20; b++) begin
      check("abort_no_start", AW'(ppu_start), AW'(1'b0));
      psum_valid = 1'b1;
      psum_data  = rand_beat();
      if (b == 0) k_tiles = 8'd2;
      @(negedge clk);
    end
    check("abort_busy", AW'(busy), AW'(1'b1));
    check("abort_no_start", AW'(ppu_start), AW'(1'b0));
    rst_n      = 1'b0;
    psum_valid = 1'b0;
    #1;
    check("abort_rst_ready", AW'(psum_ready), AW'(1'b0));
    check("abort_rst_busy", AW'(busy), AW'(1'b0));
    check("abort_rst_start", AW'(ppu_start), AW'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", AW'(psum_ready), AW'(1'b1));
    fill_random(16);
    run_tile(1, 1'b0, '0, 1'b0);

    // Random tiles, with i_k_tiles changing after the first beat
    for (int t = 0; t < 3; t++) begin
      k = $urandom_range(1, 3);
      fill_random(16 * k);
      run_tile(k, 1'b0, '0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
